miner_multi_csr: RTL

Avalon-MM slave that configures and collects results from NUM_CORES SHA3-256 mining cores sharing one clock. Holds header, difficulty, start nonce, per-core nonce stride and control. Captures every core's solution into a solution FIFO, and raises a level IRQ while solutions are pending. Sits between the HPS bridge and an array of sha3_256_miner-class cores; clock-domain crossing is outside this block.

---
 rtl/miner_pkg.sv | 52 +++++
 rtl/miner_soln_fifo.sv | 78 +++++++
 rtl/miner_multi_csr.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the multi-core SHA3 miner CSR block: register word
// addresses, CTL/STAT bit positions, the ID constant and the solution entry
// carried through the solution FIFO.
// -----------------------------------------------------------------------------
package miner_pkg;

    // Register word addresses (Avalon word address, 6 bits).
    localparam logic [5:0] ADDR_STAT     = 6'd0;
    localparam logic [5:0] ADDR_ID       = 6'd1;
    localparam logic [5:0] ADDR_CTL      = 6'd2;
    localparam logic [5:0] ADDR_STRIDE   = 6'd3;
    localparam logic [5:0] ADDR_SOLN     = 6'd4;   // 4..7, least-significant word first
    localparam logic [5:0] ADDR_SOLN_POP = 6'd8;
    localparam logic [5:0] ADDR_HDR      = 6'd16;  // 16..23, most-significant word first
    localparam logic [5:0] ADDR_DIFF     = 6'd24;  // 24..31, most-significant word first
    localparam logic [5:0] ADDR_START    = 6'd32;  // 32..35, most-significant word first

    // CTL bit positions.
    localparam int CTL_RUN           = 0;
    localparam int CTL_TEST          = 1;
    localparam int CTL_HALT          = 2;
    localparam int CTL_IRQ_EN        = 3;
    localparam int CTL_OVF_CLR       = 4;
    localparam int CTL_PAD_LAST_LSB  = 16;
    localparam int CTL_PAD_FIRST_LSB = 24;
    // Bits actually stored in CTL; the overflow-clear strobe is never stored.
    localparam logic [31:0] CTL_WR_MASK = 32'hFFFF_000F;

    // STAT bit positions.
    localparam int STAT_NONEMPTY = 0;
    localparam int STAT_BUSY     = 1;
    localparam int STAT_TEST     = 2;
    localparam int STAT_OVF      = 3;
    localparam int STAT_CLK_LSB  = 8;
    localparam int STAT_MAJ_LSB  = 16;
    localparam int STAT_MIN_LSB  = 20;
    localparam int STAT_CNT_LSB  = 24;

    // ASCII "SHA3".
    localparam logic [31:0] ID_VALUE = 32'h5348_4133;

    // Widest supported nonce; narrower nonces are zero-extended into entries.
    localparam int NONCE_MAX_W = 128;

    typedef struct packed {
        logic [7:0]             core_idx;
        logic [NONCE_MAX_W-1:0] nonce;
    } soln_entry_t;

endpackage

// File: rtl/miner_soln_fifo.sv
// -----------------------------------------------------------------------------
// miner_soln_fifo
// Synchronous FIFO for captured solutions. A push is accepted when not full,
// or when full and a pop happens in the same cycle. Flush empties the FIFO and
// overrides any same-cycle push or pop.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       push request, data_i written at the tail when accepted
//   pop_i        pop request, ignored when empty
//   flush_i      empty the FIFO
//   data_o       head entry (stale when empty_o is high)
//   count_o      number of entries held
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0
// -----------------------------------------------------------------------------
module miner_soln_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage array has no reset; validity is defined solely by the
    // pointers and count, so resetting the array would only cost area.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/miner_multi_csr.sv
// -----------------------------------------------------------------------------
// miner_multi_csr
// Avalon-MM CSR slave for an array of SHA3-256 mining cores. Holds header,
// difficulty, start nonce, nonce stride and control; captures each core's
// solution into a one-deep slot, drains slots in core-index priority order
// into a solution FIFO and raises a level IRQ while solutions are pending.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   address/read/write/
//   writedata/readdata          Avalon-MM word port, read latency 1
//   irq                         irq_en & FIFO non-empty, registered
//   header, difficulty          256-bit work parameters
//   core_start_nonce            per-core start nonce, START + i*STRIDE
//   core_run/test/halt          CTL[0]/[1]/[2]
//   pad_first, pad_last         CTL[31:24], CTL[23:16]
//   core_found/nonce/busy       per-core solution pulse, nonce, busy
// -----------------------------------------------------------------------------
module miner_multi_csr
    import miner_pkg::*;
#(
    parameter int         NUM_CORES  = 4,
    parameter int         NONCE_W    = 64,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] CLK_MHZ    = 8'd60,
    parameter logic [3:0] MAJ_VER    = 4'd0,
    parameter logic [3:0] MIN_VER    = 4'd0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [5:0]                     address,
    input  logic                           read,
    input  logic                           write,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    output logic                           irq,
    output logic [255:0]                   header,
    output logic [255:0]                   difficulty,
    output logic [NUM_CORES*NONCE_W-1:0]   core_start_nonce,
    output logic                           core_run,
    output logic                           core_test,
    output logic                           core_halt,
    output logic [7:0]                     pad_first,
    output logic [7:0]                     pad_last,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
    input  logic [NUM_CORES-1:0]           core_busy
);
    localparam int NW    = NONCE_W / 32;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Register file.
    logic [7:0][31:0]                  hdr_q;
    logic [7:0][31:0]                  diff_q;
    logic [NW-1:0][31:0]               start_q;
    logic [31:0]                       stride_q;
    logic [31:0]                       ctl_q;
    logic [NUM_CORES-1:0][NONCE_W-1:0] start_nonce_q;
    logic [31:0]                       readdata_q;
    logic [31:0]                       rdata;

    // Capture slots, overflow and IRQ.
    logic [NUM_CORES-1:0]              slot_vld_q,   slot_vld_d;
    logic [NUM_CORES-1:0][NONCE_W-1:0] slot_nonce_q, slot_nonce_d;
    logic                              ovf_q, ovf_d;
    logic                              irq_q;

    // Drain and FIFO.
    logic                drain_hit;
    logic [7:0]          drain_idx;
    logic [NONCE_W-1:0]  drain_nonce;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    soln_entry_t         push_entry, head_entry;

    logic wr_ctl, flush, ovf_clr;

    assign wr_ctl   = write && (address == ADDR_CTL);
    // Flush only on a rising edge of run, so rewriting run=1 keeps solutions.
    assign flush    = wr_ctl && writedata[CTL_RUN] && !ctl_q[CTL_RUN];
    assign ovf_clr  = wr_ctl && writedata[CTL_OVF_CLR];
    assign fifo_pop = read && (address == ADDR_SOLN_POP) && !fifo_empty;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q    <= '0;
            diff_q   <= '0;
            start_q  <= '0;
            stride_q <= '0;
            ctl_q    <= '0;
        end else if (write) begin
            if (address == ADDR_CTL)    ctl_q    <= writedata & CTL_WR_MASK;
            if (address == ADDR_STRIDE) stride_q <= writedata;
            for (int k = 0; k < 8; k++) begin
                if (address == 6'(ADDR_HDR + k))  hdr_q[7-k]  <= writedata;
                if (address == 6'(ADDR_DIFF + k)) diff_q[7-k] <= writedata;
            end
            for (int k = 0; k < NW; k++) begin
                if (address == 6'(ADDR_START + k)) start_q[NW-1-k] <= writedata;
            end
        end
    end

    // Per-core start nonces, one cycle behind START/STRIDE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_nonce_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                start_nonce_q[i] <= start_q + NONCE_W'(i) * NONCE_W'(stride_q);
            end
        end
    end

    // ------------------------------------------------------------ drain select
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        drain_hit   = 1'b0;
        drain_idx   = '0;
        drain_nonce = '0;
        // Scan downwards so the lowest occupied index is the one that sticks.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (slot_vld_q[i]) begin
                drain_hit   = 1'b1;
                drain_idx   = 8'(i);
                drain_nonce = slot_nonce_q[i];
            end
        end
    end

    assign fifo_push = drain_hit && (!fifo_full || fifo_pop);

    always_comb begin
        push_entry          = '0;
        push_entry.core_idx = drain_idx;
        push_entry.nonce    = NONCE_MAX_W'(drain_nonce);
    end

    // ------------------------------------------------------- slots / overflow
    always_comb begin
        slot_vld_d   = slot_vld_q;
        slot_nonce_d = slot_nonce_q;
        ovf_d        = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (fifo_push && (drain_idx == 8'(i))) slot_vld_d[i] = 1'b0;
            // A pulse that meets an occupied slot is lost, even if that slot
            // drains in the same cycle.
            if (core_found[i]) begin
                if (slot_vld_q[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    slot_vld_d[i]   = 1'b1;
                    slot_nonce_d[i] = core_nonce[i*NONCE_W +: NONCE_W];
                end
            end
        end
        if (flush) begin
            slot_vld_d = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q   <= '0;
            slot_nonce_q <= '0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_nonce_q <= slot_nonce_d;
            ovf_q        <= ovf_d;
            irq_q        <= ctl_q[CTL_IRQ_EN] && !fifo_empty;
        end
    end

    miner_soln_fifo #(
        .WIDTH ($bits(soln_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------------------------------------------------------- readback
    always_comb begin
        rdata = '0;
        if (address == ADDR_STAT) begin
            rdata[STAT_NONEMPTY]           = !fifo_empty;
            rdata[STAT_BUSY]               = |core_busy;
            rdata[STAT_TEST]               = ctl_q[CTL_TEST];
            rdata[STAT_OVF]                = ovf_q;
            rdata[STAT_CLK_LSB +: 8]       = CLK_MHZ;
            rdata[STAT_MAJ_LSB +: 4]       = MAJ_VER;
            rdata[STAT_MIN_LSB +: 4]       = MIN_VER;
            rdata[STAT_CNT_LSB +: 8]       = 8'(fifo_count);
        end
        if (address == ADDR_ID)     rdata = ID_VALUE;
        if (address == ADDR_CTL)    rdata = ctl_q;
        if (address == ADDR_STRIDE) rdata = stride_q;
        // Entries are zero-extended, so words past NONCE_W/32 read as 0.
        for (int k = 0; k < 4; k++) begin
            if ((address == 6'(ADDR_SOLN + k)) && !fifo_empty) begin
                rdata = head_entry.nonce[32*k +: 32];
            end
        end
        if ((address == ADDR_SOLN_POP) && !fifo_empty) rdata = {24'd0, head_entry.core_idx};
        for (int k = 0; k < 8; k++) begin
            if (address == 6'(ADDR_HDR + k))  rdata = hdr_q[7-k];
            if (address == 6'(ADDR_DIFF + k)) rdata = diff_q[7-k];
        end
        for (int k = 0; k < NW; k++) begin
            if (address == 6'(ADDR_START + k)) rdata = start_q[NW-1-k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) readdata_q <= '0;
        else        readdata_q <= read ? rdata : '0;
    end

    assign readdata         = readdata_q;
    assign irq              = irq_q;
    assign header           = hdr_q;
    assign difficulty       = diff_q;
    assign core_start_nonce = start_nonce_q;
    assign core_run         = ctl_q[CTL_RUN];
    assign core_test        = ctl_q[CTL_TEST];
    assign core_halt        = ctl_q[CTL_HALT];
    assign pad_first        = ctl_q[CTL_PAD_FIRST_LSB +: 8];
    assign pad_last         = ctl_q[CTL_PAD_LAST_LSB +: 8];

endmodule
